// File: rtl/sram_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sram_pkg
//  Purpose  : Shared types and constants for the 32-bit to 16-bit SRAM
//             controller (state encoding, address map, bus widths).
//  Revision : 1.0 - initial release
// ============================================================================
package sram_pkg;

    // Access sequencer states: idle, low halfword, high halfword, completion
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [31:0] ADDR_BASE = 32'd1024;
    localparam int          SRAM_AW   = 18;
    localparam int          SRAM_DW   = 16;

    // SRAM word index of a CPU byte address; wraps modulo the SRAM word count
    function automatic logic [SRAM_AW-2:0] word_index(input logic [31:0] addr,
                                                      input logic [31:0] base);
        return (SRAM_AW-1)'((addr - base) >> 2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_phase_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : sram_phase_cnt
//  Purpose  : Counts the cycles of one halfword bus phase and flags the last
//             one. Holds at the terminal value until cleared.
//  Revision : 1.0 - initial release
// ============================================================================
module sram_phase_cnt
    import sram_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int CW          = $clog2(WAIT_CYCLES + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    output logic [CW-1:0] cnt,
    output logic          done
);

    assign done = (cnt == CW'(WAIT_CYCLES - 1));

    // Phase cycle counter: cleared between phases, saturates on the last cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (!done) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/sram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sram_ctrl
//  Purpose  : Splits 32-bit load/store requests into two 16-bit SRAM accesses
//             (low half then high half) and signals completion on ready.
//  Revision : 1.0 - initial release
// ============================================================================
module sram_ctrl
    import sram_pkg::*;
#(
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] ADDR_BASE   = sram_pkg::ADDR_BASE
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    input  logic [SRAM_DW-1:0] sram_dq_i,
    output logic [SRAM_DW-1:0] sram_dq_o,
    output logic               sram_dq_oe,
    output logic               sram_we_n,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_ub_n,
    output logic               sram_lb_n
);

    localparam int CW = $clog2(WAIT_CYCLES + 1);

    state_t             r_state;
    logic               r_wr;
    logic [CW-1:0]      w_cnt;
    logic               w_done;
    logic               w_clear;
    logic               w_req;
    logic [SRAM_AW-2:0] w_widx;

    // Chip is permanently selected with both byte lanes enabled
    assign sram_ce_n = 1'b0;
    assign sram_oe_n = 1'b0;
    assign sram_ub_n = 1'b0;
    assign sram_lb_n = 1'b0;

    assign w_req  = rd_en | wr_en;
    // Address is not latched: the requester holds it for the whole access
    assign w_widx = word_index(address, ADDR_BASE);

    // Counter runs only inside a phase and restarts at each phase boundary
    assign w_clear = ((r_state != ST_LO) && (r_state != ST_HI)) || w_done;

    assign ready = ((r_state == ST_IDLE) && !w_req) || (r_state == ST_DONE);

    sram_phase_cnt #(
        .WAIT_CYCLES (WAIT_CYCLES),
        .CW          (CW)
    ) u_phase_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (w_clear),
        .cnt   (w_cnt),
        .done  (w_done)
    );

    // Access sequencer; bus outputs are registered from the upcoming state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_wr       <= 1'b0;
            read_data  <= '0;
            sram_addr  <= '0;
            sram_dq_o  <= '0;
            sram_we_n  <= 1'b1;
            sram_dq_oe <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_state    <= ST_LO;
                        r_wr       <= wr_en;
                        sram_addr  <= {w_widx, 1'b0};
                        sram_dq_o  <= write_data[15:0];
                        sram_we_n  <= ~wr_en;
                        sram_dq_oe <= wr_en;
                    end
                end
                ST_LO: begin
                    if (w_done) begin
                        r_state   <= ST_HI;
                        sram_addr <= {w_widx, 1'b1};
                        sram_dq_o <= write_data[31:16];
                        if (!r_wr) begin
                            read_data[15:0] <= sram_dq_i;
                        end
                    end
                end
                ST_HI: begin
                    if (w_done) begin
                        r_state    <= ST_DONE;
                        sram_we_n  <= 1'b1;
                        sram_dq_oe <= 1'b0;
                        if (!r_wr) begin
                            read_data[31:16] <= sram_dq_i;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sram_ctrl
//  Purpose  : Self-checking bench for sram_ctrl with a small SRAM model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sram_ctrl;

    localparam int W = 2;

    logic        clk;
    logic        reset;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_i;
    logic [15:0] sram_dq_o;
    logic        sram_dq_oe;
    logic        sram_we_n;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_ub_n;
    logic        sram_lb_n;

    logic        mem_init;
    logic [15:0] mem [0:255];

    int checks;
    int errors;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } vec_t;

    sram_ctrl #(
        .WAIT_CYCLES (W),
        .ADDR_BASE   (32'd1024)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rd_en      (rd_en),
        .wr_en      (wr_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .sram_addr  (sram_addr),
        .sram_dq_i  (sram_dq_i),
        .sram_dq_o  (sram_dq_o),
        .sram_dq_oe (sram_dq_oe),
        .sram_we_n  (sram_we_n),
        .sram_ce_n  (sram_ce_n),
        .sram_oe_n  (sram_oe_n),
        .sram_ub_n  (sram_ub_n),
        .sram_lb_n  (sram_lb_n)
    );

    always #5 clk = ~clk;

    // SRAM model: asynchronous read, write on the clock edge while enabled
    assign sram_dq_i = mem[sram_addr[7:0]];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) begin
                mem[i] <= 16'(i) ^ 16'h5A00;
            end
            mem[2] <= 16'h1234;
            mem[3] <= 16'hABCD;
            mem[6] <= 16'h6666;
            mem[7] <= 16'h7777;
        end else if (!sram_we_n && sram_dq_oe) begin
            mem[sram_addr[7:0]] <= sram_dq_o;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one request from idle and check every cycle through DONE
    task automatic run_access(input vec_t v, input bit drop);
        logic [17:0] base_a;
        int          ph;
        base_a     = {17'((v.addr - 32'd1024) >> 2), 1'b0};
        rd_en      = v.rd;
        wr_en      = v.wr;
        address    = v.addr;
        write_data = v.wdata;
        #1;
        check("ready_idle_req", 32'(ready), 32'd0);
        for (int c = 0; c < 2 * W; c++) begin
            @(negedge clk);
            ph = c / W;
            check("ready_busy", 32'(ready), 32'd0);
            check("sram_addr", 32'(sram_addr), 32'(base_a | 18'(ph)));
            check("we_n", 32'(sram_we_n), v.wr ? 32'd0 : 32'd1);
            check("dq_oe", 32'(sram_dq_oe), v.wr ? 32'd1 : 32'd0);
            if (v.wr) begin
                check("dq_o", 32'(sram_dq_o),
                      (ph == 1) ? 32'(v.wdata[31:16]) : 32'(v.wdata[15:0]));
            end
        end
        @(negedge clk);
        check("ready_done", 32'(ready), 32'd1);
        check("we_n_done", 32'(sram_we_n), 32'd1);
        check("dq_oe_done", 32'(sram_dq_oe), 32'd0);
        check("read_data", read_data, v.exp_rd);
        if (drop) begin
            rd_en = 1'b0;
            wr_en = 1'b0;
            @(negedge clk);
            check("ready_idle", 32'(ready), 32'd1);
            check("read_data_hold", read_data, v.exp_rd);
        end
    endtask

    vec_t vecs [9];
    vec_t v;

    initial begin
        vecs[0] = '{1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 32'h00000000};
        vecs[1] = '{1'b1, 1'b0, 32'd1028, 32'h0,        32'hABCD1234};
        vecs[2] = '{1'b1, 1'b0, 32'd1024, 32'h0,        32'hDEADBEEF};
        vecs[3] = '{1'b1, 1'b1, 32'd1032, 32'h5555AAAA, 32'hDEADBEEF};
        vecs[4] = '{1'b1, 1'b0, 32'd1032, 32'h0,        32'h5555AAAA};
        vecs[5] = '{1'b0, 1'b1, 32'd1427, 32'h0F0F1234, 32'h5555AAAA};
        vecs[6] = '{1'b1, 1'b0, 32'd1424, 32'h0,        32'h0F0F1234};
        vecs[7] = '{1'b0, 1'b1, 32'd1020, 32'hCAFEF00D, 32'h0F0F1234};
        vecs[8] = '{1'b1, 1'b0, 32'd1020, 32'h0,        32'hCAFEF00D};

        checks     = 0;
        errors     = 0;
        clk        = 1'b0;
        reset      = 1'b1;
        mem_init   = 1'b1;
        rd_en      = 1'b0;
        wr_en      = 1'b0;
        address    = 32'd0;
        write_data = 32'd0;
        repeat (3) @(negedge clk);
        reset    = 1'b0;
        mem_init = 1'b0;
        @(negedge clk);

        // Reset state with no request
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_we_n", 32'(sram_we_n), 32'd1);
        check("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
        check("rst_read_data", read_data, 32'd0);
        check("rst_sram_addr", 32'(sram_addr), 32'd0);
        check("rst_dq_o", 32'(sram_dq_o), 32'd0);
        check("rst_ctl_n", {28'd0, sram_ce_n, sram_oe_n, sram_ub_n, sram_lb_n}, 32'd0);

        // Table of single accesses, including address wrap and ignored low bits
        for (int i = 0; i < 9; i++) begin
            run_access(vecs[i], 1'b1);
        end

        // Back-to-back: load presented during the DONE cycle of a store
        v = '{1'b0, 1'b1, 32'd1040, 32'hA5A5C3C3, 32'hCAFEF00D};
        run_access(v, 1'b0);
        rd_en   = 1'b1;
        wr_en   = 1'b0;
        address = 32'd1040;
        @(negedge clk);
        check("b2b_idle_ready", 32'(ready), 32'd0);
        check("b2b_idle_we_n", 32'(sram_we_n), 32'd1);
        v = '{1'b1, 1'b0, 32'd1040, 32'h0, 32'hA5A5C3C3};
        run_access(v, 1'b1);

        // Reset during the HI phase of a store: upper half never written
        rd_en      = 1'b0;
        wr_en      = 1'b1;
        address    = 32'd1036;
        write_data = 32'h11112222;
        repeat (W + 1) @(negedge clk);
        check("mid_hi_addr", 32'(sram_addr), 32'd7);
        check("mid_hi_we_n", 32'(sram_we_n), 32'd0);
        reset = 1'b1;
        wr_en = 1'b0;
        #1;
        check("arst_we_n", 32'(sram_we_n), 32'd1);
        check("arst_dq_oe", 32'(sram_dq_oe), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("arst_ready", 32'(ready), 32'd1);
        check("arst_read_data", read_data, 32'd0);
        repeat (2) @(negedge clk);
        check("post_rst_ready", 32'(ready), 32'd1);
        v = '{1'b1, 1'b0, 32'd1036, 32'h0, 32'h77772222};
        run_access(v, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
